revaluate_driver: RTL

REVALUATE_DRIVER -- requirements
Module: revaluate_driver

---
 rtl/revaluate_driver_if.sv | 42 ++++
 rtl/revaluate_driver.sv | 137 +++++++++++++
 2 files changed

// File: rtl/revaluate_driver_if.sv
// Host and engine signal bundle for revaluate_driver.
//
// Handshakes: a job word moves host->driver on a rising clock edge where
// in_valid && in_ready. A result moves driver->host on an edge where
// out_valid && out_ack. out_valid/out_data hold until that edge. Engine
// side: eng_start is a one-cycle pulse. The engine takes eng_data on a
// cycle with eng_put_input, and offers eng_result on a cycle with
// eng_out_ready.
interface revaluate_driver_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             eng_ready;
    logic             eng_start;
    logic             eng_put_input;
    logic [WIDTH-1:0] eng_data;
    logic             eng_out_ready;
    logic [WIDTH-1:0] eng_result;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;
    logic             busy;
    logic             timeout_err;
    logic [7:0]       drop_cnt;
    logic [1:0]       fsm_state;

    modport master (
        output in_valid, in_data, eng_ready, eng_put_input, eng_out_ready,
               eng_result, out_ack,
        input  in_ready, eng_start, eng_data, out_valid, out_data, busy,
               timeout_err, drop_cnt, fsm_state
    );

    modport slave (
        input  in_valid, in_data, eng_ready, eng_put_input, eng_out_ready,
               eng_result, out_ack,
        output in_ready, eng_start, eng_data, out_valid, out_data, busy,
               timeout_err, drop_cnt, fsm_state
    );
endinterface

// File: rtl/revaluate_driver.sv
// Job driver. It buffers host operand words in a small FIFO and issues one
// job at a time to an engine. It holds each result until the host takes it.
// Each engine phase is bounded by a timer. A timed-out job is dropped and
// counted.
module revaluate_driver #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    revaluate_driver_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_PUT, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [TW-1:0]    timer;
    logic             push, pop, timer_clr, timed_out, load_out;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             err_q;
    logic [7:0]       drop_q;

    assign push             = bus.in_valid && bus.in_ready;
    assign bus.in_ready     = (count != CW'(DEPTH));
    assign bus.eng_start    = (state == ISSUE);
    assign bus.eng_data     = (state == WAIT_PUT) ? mem[rd_ptr] : '0;
    assign bus.busy         = (state != IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.timeout_err  = err_q;
    assign bus.drop_cnt     = drop_q;
    assign bus.fsm_state    = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, FIFO pop, timer clear and timeout decision. Exit events are tested before expiry.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        timer_clr = 1'b0;
        timed_out = 1'b0;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && bus.eng_ready && !out_valid_q) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = WAIT_PUT;
                timer_clr = 1'b1;
            end
            WAIT_PUT: begin
                if (bus.eng_put_input) begin
                    pop       = 1'b1;
                    timer_clr = 1'b1;
                    state_nxt = RUN;
                end else if (timer == TLAST) begin
                    pop       = 1'b1;
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (bus.eng_out_ready) begin
                    load_out  = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TLAST) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage. The memory needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle cancel in count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Phase timer. It restarts on entry to WAIT_PUT or RUN and counts while in either state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       timer <= '0;
        else if (timer_clr)                            timer <= '0;
        else if (state == WAIT_PUT || state == RUN)    timer <= timer + 1'b1;
    end

    // Result holding register plus sticky error and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.eng_result;
            end else if (out_valid_q && bus.out_ack) begin
                out_valid_q <= 1'b0;
            end
            if (timed_out) begin
                err_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
            end
        end
    end
endmodule
